// File: rtl/cpu_types_pkg.sv
// +-----------------------------------------------------------------------+
// | cpu_types_pkg                                                         |
// | Shared CPU types: word, fetch queue record and fetch FSM encoding.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t npc;
    word_t instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    FQ_RUN    = 1'b0,
    FQ_HALTED = 1'b1
  } fetch_state_t;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +-----------------------------------------------------------------------+
// | fetch_fifo                                                            |
// | DEPTH x fetch_entry_t synchronous FIFO with push/pop/flush and head.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_data,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int                   c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]     c_FULL    = (c_PTR_W + 1)'(DEPTH);
  localparam logic [c_PTR_W:0]     c_CNT_ONE = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);

  fetch_entry_t       r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full       = (r_count == c_FULL);
  assign head_valid = (r_count != '0);
  assign head       = r_mem[r_rd_ptr];
  assign count      = r_count;

  // Guard against misuse so the pointers can never lap each other.
  assign w_push = push & ~full;
  assign w_pop  = pop & head_valid;

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !RST && !flush) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// +-----------------------------------------------------------------------+
// | fetch_queue                                                           |
// | Prefetch queue between icache port and decode; halt and redirect.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter logic [5:0]  HALT_OP = HALT_OPCODE,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   iREN,
  output logic [31:0]            iaddr,
  input  logic                   ihit,
  input  logic [31:0]            iload,
  input  logic                   dmem_busy,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   dec_ready,
  output logic                   if_valid,
  output logic [31:0]            if_instr,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_npc,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] occupancy
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  word_t        r_fetch_pc;
  fetch_entry_t w_wr_entry;
  fetch_entry_t w_head;
  logic         w_head_valid;
  logic         w_full;
  logic         w_run;
  logic         w_push;
  logic         w_pop;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= FQ_RUN;
    else     r_state <= w_state_next;
  end

  // Next-state: a redirect cancels any halt, including one fetched this cycle
  always_comb begin
    w_state_next = r_state;
    if (redirect)
      w_state_next = FQ_RUN;
    else if (w_push && (iload[31:26] == HALT_OP))
      w_state_next = FQ_HALTED;
  end

  // Output decode
  always_comb begin
    w_run  = (r_state == FQ_RUN);
    halted = (r_state == FQ_HALTED);
  end

  assign iREN   = ~RST & w_run & ~w_full & ~dmem_busy & ~redirect;
  assign iaddr  = r_fetch_pc;
  assign w_push = iREN & ihit;
  assign w_pop  = w_head_valid & dec_ready & ~redirect;

  assign w_wr_entry = '{pc: r_fetch_pc, npc: r_fetch_pc + PC_STEP, instr: iload};

  always_ff @(posedge CLK) begin
    if (RST)           r_fetch_pc <= PC_INIT;
    else if (redirect) r_fetch_pc <= {redirect_pc[31:2], 2'b00};
    else if (w_push)   r_fetch_pc <= r_fetch_pc + PC_STEP;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (redirect),
    .wr_data    (w_wr_entry),
    .head       (w_head),
    .head_valid (w_head_valid),
    .full       (w_full),
    .count      (occupancy)
  );

  assign if_valid = w_head_valid;
  assign if_instr = w_head_valid ? w_head.instr : '0;
  assign if_pc    = w_head_valid ? w_head.pc    : '0;
  assign if_npc   = w_head_valid ? w_head.npc   : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// +-----------------------------------------------------------------------+
// | tb_fetch_queue                                                        |
// | Directed bench for fetch_queue with queue-based reference model.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_queue;

  localparam int c_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
  } rec_t;

  logic        CLK = 1'b0;
  logic        RST, ihit, dmem_busy, redirect, dec_ready;
  logic [31:0] iload, redirect_pc;
  logic        iREN, if_valid, halted;
  logic [31:0] iaddr, if_instr, if_pc, if_npc;
  logic [2:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  rec_t        m_q [$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_known = 0;

  always #5 CLK = ~CLK;

  fetch_queue #(.DEPTH(c_DEPTH)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dmem_busy(dmem_busy), .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_npc(if_npc), .halted(halted), .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_iren();
    return !RST && !m_halt && (m_q.size() < c_DEPTH) && !dmem_busy && !redirect;
  endfunction

  // Compare at the falling edge, then advance the model with the same inputs.
  task automatic cyc();
    bit do_push;
    bit do_pop;
    @(negedge CLK);
    chk("iREN", {31'b0, iREN}, {31'b0, exp_iren()});
    if (m_known) begin
      chk("occupancy", {29'b0, occupancy}, m_q.size());
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_q.size() != 0});
      chk("if_pc", if_pc, m_q.size() != 0 ? m_q[0].pc : 32'h0);
      chk("if_npc", if_npc, m_q.size() != 0 ? m_q[0].npc : 32'h0);
      chk("if_instr", if_instr, m_q.size() != 0 ? m_q[0].instr : 32'h0);
      chk("halted", {31'b0, halted}, {31'b0, m_halt});
      chk("iaddr", iaddr, m_pc);
    end
    if (RST) begin
      m_q.delete();
      m_pc    = 32'h0;
      m_halt  = 0;
      m_known = 1;
    end else if (redirect) begin
      m_q.delete();
      m_pc   = redirect_pc & 32'hFFFF_FFFC;
      m_halt = 0;
    end else begin
      do_push = exp_iren() && ihit;
      do_pop  = (m_q.size() != 0) && dec_ready;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back('{pc: m_pc, npc: m_pc + 32'd4, instr: iload});
        m_pc = m_pc + 32'd4;
        if (iload[31:26] == 6'b111111) m_halt = 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect = 1; redirect_pc = tgt;
    cyc();
    redirect = 0;
  endtask

  initial begin
    RST = 1; ihit = 0; dmem_busy = 0; redirect = 0; dec_ready = 0;
    iload = 32'h0; redirect_pc = 32'h0;

    // Sequential fetch with decode always ready
    cyc(); cyc();
    RST = 0; ihit = 1; dec_ready = 1; iload = 32'h2001_0005;
    #1;
    chk("rst_occ", {29'b0, occupancy}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    cyc();
    chk("seq_pc0", if_pc, 32'h0);
    chk("seq_npc0", if_npc, 32'h4);
    chk("seq_instr0", if_instr, 32'h2001_0005);
    cyc();
    chk("seq_pc1", if_pc, 32'h4);
    cyc();
    chk("seq_pc2", if_pc, 32'h8);
    chk("seq_npc2", if_npc, 32'hC);

    // Fill to DEPTH with decode stalled, then free one slot
    RST = 1; cyc(); RST = 0; dec_ready = 0;
    repeat (4) cyc();
    chk("full_occ", {29'b0, occupancy}, 32'd4);
    chk("full_iren", {31'b0, iREN}, 32'd0);
    chk("full_iaddr", iaddr, 32'h10);
    dec_ready = 1; cyc(); dec_ready = 0;
    #1;
    chk("pop_occ", {29'b0, occupancy}, 32'd3);
    chk("pop_iren", {31'b0, iREN}, 32'd1);
    cyc();
    chk("refill_occ", {29'b0, occupancy}, 32'd4);
    chk("refill_iaddr", iaddr, 32'h14);

    // Redirect flushes a partially filled queue
    do_redirect(32'h34);
    repeat (3) cyc();
    chk("pre_redir_iaddr", iaddr, 32'h40);
    ihit = 0;
    do_redirect(32'h103);
    #1;
    chk("redir_occ", {29'b0, occupancy}, 32'd0);
    chk("redir_valid", {31'b0, if_valid}, 32'd0);
    chk("redir_iaddr", iaddr, 32'h100);
    chk("redir_iren", {31'b0, iREN}, 32'd1);

    // Halt opcode: queued, freezes fetch, cancelled by redirect
    do_redirect(32'h20);
    ihit = 1; iload = 32'hFC00_0000;
    cyc();
    chk("halt_flag", {31'b0, halted}, 32'd1);
    chk("halt_iren", {31'b0, iREN}, 32'd0);
    chk("halt_instr", if_instr, 32'hFC00_0000);
    chk("halt_pc", if_pc, 32'h20);
    dec_ready = 1; cyc(); cyc(); dec_ready = 0;
    chk("halt_drained", {29'b0, occupancy}, 32'd0);
    chk("halt_frozen_pc", iaddr, 32'h24);
    iload = 32'h2001_0005;
    do_redirect(32'h80);
    #1;
    chk("resume_halted", {31'b0, halted}, 32'd0);
    chk("resume_iaddr", iaddr, 32'h80);
    chk("resume_iren", {31'b0, iREN}, 32'd1);

    // dmem_busy suppresses fetch
    dmem_busy = 1;
    repeat (3) cyc();
    chk("busy_occ", {29'b0, occupancy}, 32'd0);
    chk("busy_iaddr", iaddr, 32'h80);
    dmem_busy = 0;
    cyc();
    chk("unbusy_occ", {29'b0, occupancy}, 32'd1);
    chk("unbusy_iaddr", iaddr, 32'h84);

    // Reset while full and halted
    cyc(); cyc();
    iload = 32'hFC00_0001;
    cyc();
    chk("fh_occ", {29'b0, occupancy}, 32'd4);
    chk("fh_halted", {31'b0, halted}, 32'd1);
    RST = 1; cyc(); RST = 0;
    #1;
    chk("fh_rst_occ", {29'b0, occupancy}, 32'd0);
    chk("fh_rst_halted", {31'b0, halted}, 32'd0);
    chk("fh_rst_iaddr", iaddr, 32'h0);
    chk("fh_rst_pc", if_pc, 32'h0);
    chk("fh_rst_instr", if_instr, 32'h0);

    // Mixed traffic checked against the model only
    for (int i = 0; i < 300; i++) begin
      ihit        = ($urandom_range(0, 3) != 0);
      dec_ready   = ($urandom_range(0, 2) != 0);
      dmem_busy   = ($urandom_range(0, 5) == 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      iload       = ($urandom_range(0, 15) == 0) ? 32'hFC00_0000 | ($urandom & 32'h03FF_FFFF) : $urandom & 32'h03FF_FFFF;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised successor to the single-register fetch stage. It decouples the instruction-cache port from decode with a DEPTH-entry prefetch queue of {pc, npc, instr} records. It keeps fetching sequentially while decode is stalled. Redirects (branch/jump/jr resolved downstream) flush the queue. A halt opcode freezes fetch until a redirect cancels it. It sits between the icache port and the IF/ID boundary.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
PC_INIT, 32'h0, fetch PC after reset
HALT_OP, 6'b111111, opcode field [31:26] that stops fetch
PC_STEP, 4, sequential PC increment in bytes

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
iREN  out  1  icache read request
iaddr  out  32  icache address (current fetch_pc)
ihit  in  1  icache response valid this cycle; only meaningful while iREN=1
iload  in  32  icache instruction word, valid with ihit
dmem_busy  in  1  data access owns memory this cycle; suppresses iREN
redirect  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced 0)
dec_ready  in  1  decode accepts queue head this cycle
if_valid  out  1  queue head valid
if_instr  out  32  head instruction; 0 when empty
if_pc  out  32  head PC; 0 when empty
if_npc  out  32  head PC + PC_STEP; 0 when empty
halted  out  1  fetch frozen by halt opcode
occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- State: fetch_pc, queue storage, rd_ptr/wr_ptr ($clog2(DEPTH) bits, natural wrap), count, FSM {RUN, HALTED}.
- Reset (RST=1 at edge): fetch_pc=PC_INIT, count=0, ptrs=0, FSM=RUN. All outputs read 0 on the following cycle, and iREN=0 while RST=1.
- iREN = ~RST & (FSM==RUN) & (count<DEPTH) & ~dmem_busy & ~redirect. iaddr = fetch_pc, always driven.
- Push: iREN & ihit. Write {fetch_pc, fetch_pc+PC_STEP, iload} at wr_ptr, then fetch_pc += PC_STEP (32-bit wrap). The entry is visible on if_* the cycle after the push; there is no bypass.
- Pop: if_valid & dec_ready & ~redirect advances rd_ptr.
- Simultaneous push and pop: count unchanged. Push-only: count+1. Pop-only: count-1.
- Full (count==DEPTH): iREN low. No push is possible, so overflow cannot occur. A pop while full frees a slot that is usable next cycle.
- Empty: if_valid=0. dec_ready is ignored.
- Halt: if the pushed word has [31:26]==HALT_OP, the entry is still queued (decode sees it) and FSM goes to HALTED. HALTED keeps iREN=0 and fetch_pc frozen, and the queue drains normally. halted = (FSM==HALTED).
- Redirect (highest priority after RST): at the edge, count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[31:2],2'b00}, FSM=RUN (cancels a speculative halt). Any ihit in that cycle is discarded, since iREN is already low. Pop is suppressed. The first fetch at the new PC occurs the cycle after.
- redirect and dmem_busy together: redirect still applies. Fetch resumes once dmem_busy falls.
- RST during HALTED or a full queue: full reset as above. Reset dominates redirect.
- ihit while iREN=0 is ignored.

Decomposition:
- cpu_types_pkg additions: word_t (reuse), fetch_entry_t packed struct {word_t pc; word_t npc; word_t instr;}, typedef fetch_state_t enum {FQ_RUN, FQ_HALTED}, localparam HALT_OPCODE = 6'b111111.
- Sub-module: fetch_fifo. Parametrised DEPTH × fetch_entry_t synchronous FIFO with push/pop/flush, count, and head outputs.
- fetch_queue holds the FSM, the PC logic, and the request gating.

Test Plan:
- Reset then ihit held 1, dec_ready=1, iload=32'h2001_0005 -> pushes at 0,4,8. if_valid rises on cycle 2. if_pc sequence 0,4,8. if_npc = if_pc+4.
- dec_ready=0, ihit=1, DEPTH=4 -> occupancy reaches 4 after 4 pushes, then iREN=0 and fetch_pc=16. One pop -> iREN=1 next cycle, fetch at 16.
- Queue at 3 entries, fetch_pc=0x40, redirect=1 with redirect_pc=0x103 -> next cycle occupancy=0, if_valid=0, iaddr=0x100, iREN=1.
- Fetch 0xFC00_0000 at PC 0x20 -> entry queued, halted=1, iREN=0. Drain: if_instr=0xFC00_0000 with if_pc=0x20. A later redirect to 0x80 -> halted=0, fetch resumes at 0x80.
- dmem_busy=1 for 3 cycles with ihit=1 -> iREN=0, no pushes, fetch_pc unchanged. Pushes resume on the first cycle dmem_busy=0.
- RST asserted with queue full and FSM HALTED -> next cycle occupancy=0, halted=0, iaddr=PC_INIT, all if_* = 0.
